// File: rtl/lockin_demod_pkg.sv
// Shared types, constants and elaboration-time helpers for the lock-in demodulator.
package lockin_demod_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned PROD_W   = 32;

   // Offset-binary zero code of the ADC
   localparam logic [SAMPLE_W-1:0] SAMPLE_OFFSET = 16'h8000;

   // pi in Q30 fixed point, used only when building the sine table
   localparam longint PI_Q30 = 64'sd3373259426;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Per-sample mixer products travelling from P2 into the accumulators
   typedef struct packed {
      logic signed [PROD_W-1:0] i;
      logic signed [PROD_W-1:0] q;
   } iq_prod_t;

   // Accumulator width for a block of 2^log2n products
   function automatic int unsigned acc_width(input int unsigned log2n);
      return PROD_W + log2n;
   endfunction

   // Quarter-wave index offset turning a sine lookup into a cosine lookup
   function automatic int unsigned quad_offset(input int unsigned lut_aw);
      return 32'd1 << (lut_aw - 2);
   endfunction

   // round(32767*sin(2*pi*k/2^aw)) via quarter-wave symmetry and a Q30 Taylor series
   function automatic logic signed [15:0] sine_entry(input int unsigned k, input int unsigned aw);
      longint     quarter;
      longint     j;
      longint     x;
      longint     x2;
      longint     term;
      longint     sum;
      longint     mag;
      logic [1:0] quad;
      quarter = 64'sd1 <<< (aw - 2);
      quad    = 2'(k >> (aw - 2));
      j       = longint'(k) & (quarter - 64'sd1);
      if (quad[0]) j = quarter - j;
      x    = (64'sd2 * PI_Q30 * j) >>> aw;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 8; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         sum  = sum + term;
      end
      mag = (64'sd32767 * sum + (64'sd1 <<< 29)) >>> 30;
      if (quad[1]) mag = -mag;
      return 16'(mag);
   endfunction

endpackage

// File: rtl/lockin_demod_sine_rom.sv
// Full-wave sine table with two synchronous read ports (sin and cos), one-cycle latency.
// Contents are produced at elaboration from the package table generator.
module lockin_demod_sine_rom
   import lockin_demod_pkg::*;
#(
   parameter int unsigned AW = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [AW-1:0]       sin_addr_i,
   input  logic [AW-1:0]       cos_addr_i,
   output logic signed [15:0]  sin_o,
   output logic signed [15:0]  cos_o
);

   localparam int unsigned DEPTH = 32'd1 << AW;

   logic signed [15:0] rom [DEPTH];
   logic signed [15:0] sin_q;
   logic signed [15:0] cos_q;

   // Constant table contents
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic signed [15:0] ENTRY = sine_entry(k, AW);
      assign rom[k] = ENTRY;
   end

   // Registered dual read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sin_q <= '0;
         cos_q <= '0;
      end else begin
         sin_q <= rom[sin_addr_i];
         cos_q <= rom[cos_addr_i];
      end
   end

   assign sin_o = sin_q;
   assign cos_o = cos_q;

endmodule

// File: rtl/lockin_demod.sv
// Lock-in demodulator: mixes ADC samples with an NCO sin/cos reference and
// emits block means of the I/Q products every 2^LOG2N accepted samples.
module lockin_demod
   import lockin_demod_pkg::*;
#(
   parameter int unsigned LOG2N   = 10,
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned LUT_AW  = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [PHASE_W-1:0]   phase_inc_i,
   input  logic                 phase_clr_i,
   input  logic [SAMPLE_W-1:0]  sample_i,
   input  logic                 sample_valid_i,
   output logic signed [31:0]   i_out_o,
   output logic signed [31:0]   q_out_o,
   output logic                 out_valid_o,
   output logic                 busy_o
);

   localparam int unsigned ACC_W = acc_width(LOG2N);
   localparam logic [LOG2N-1:0]  CNT_LAST = '1;
   localparam logic [LUT_AW-1:0] COS_OFF  = LUT_AW'(quad_offset(LUT_AW));

   state_e                      state_q, state_d;
   logic                        accept_c, close_c, flush_c, latch_inc_c;

   logic [PHASE_W-1:0]          phase_q, phase_d;
   logic [PHASE_W-1:0]          inc_q;
   logic [LOG2N-1:0]            count_q, count_d;

   logic signed [SAMPLE_W-1:0]  s0_q, s1_q;
   logic [LUT_AW-1:0]           idx0_q;
   logic                        v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
   logic                        last0_q, last1_q, last2_q, last0_d, last1_d, last2_d;

   logic signed [15:0]          rom_sin, rom_cos;
   iq_prod_t                    prod_q, prod_d;

   logic signed [ACC_W-1:0]     acc_i_q, acc_q_q, acc_i_d, acc_q_d;
   logic signed [ACC_W-1:0]     sum_i_c, sum_q_c;
   logic signed [31:0]          i_out_q, q_out_q, i_out_d, q_out_d;
   logic                        out_valid_q, out_valid_d;
   logic                        busy_q, busy_d;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: en_i alone moves between idle and running
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (en_i)  state_d = ST_RUN;
         ST_RUN:  if (!en_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM controls: sample acceptance, block close, flush, increment latch
   always_comb begin
      accept_c    = 1'b0;
      close_c     = 1'b0;
      flush_c     = 1'b0;
      latch_inc_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            flush_c     = 1'b1;
            latch_inc_c = en_i;
         end
         ST_RUN: begin
            if (!en_i) begin
               flush_c = 1'b1;
            end else begin
               accept_c    = sample_valid_i;
               close_c     = sample_valid_i && (count_q == CNT_LAST);
               latch_inc_c = close_c;
            end
         end
         default: flush_c = 1'b1;
      endcase
   end

   // NCO phase: clear wins over the increment of a coincident sample
   always_comb begin
      phase_d = phase_q;
      if (phase_clr_i)   phase_d = '0;
      else if (accept_c) phase_d = phase_q + inc_q;
   end

   // Block counter and pipeline valid/last tags
   always_comb begin
      count_d = count_q;
      if (flush_c)       count_d = '0;
      else if (accept_c) count_d = close_c ? '0 : count_q + LOG2N'(1);
      v0_d    = accept_c;
      last0_d = close_c;
      v1_d    = v0_q & ~flush_c;
      last1_d = last0_q;
      v2_d    = v1_q & ~flush_c;
      last2_d = last1_q;
      busy_d  = (state_d == ST_RUN) && ((count_d != '0) || v0_d || v1_d || v2_d);
   end

   // Control registers: phase, increment, count, tags, busy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= '0;
         inc_q   <= '0;
         count_q <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         if (latch_inc_c) inc_q <= phase_inc_i;
         count_q <= count_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         last2_q <= last2_d;
         busy_q  <= busy_d;
      end
   end

   // P0: signed sample and LUT index from the pre-increment phase
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s0_q   <= '0;
         idx0_q <= '0;
      end else if (accept_c) begin
         s0_q   <= signed'(sample_i ^ SAMPLE_OFFSET);
         idx0_q <= phase_q[PHASE_W-1 -: LUT_AW];
      end
   end

   // P1: reference lookup, sample delayed to stay aligned with the ROM output
   lockin_demod_sine_rom #(
      .AW (LUT_AW)
   ) u_sine_rom (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sin_addr_i (idx0_q),
      .cos_addr_i (idx0_q + COS_OFF),
      .sin_o      (rom_sin),
      .cos_o      (rom_cos)
   );

   // P1 sample delay
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) s1_q <= '0;
      else       s1_q <= s0_q;
   end

   // P2 mixer products
   always_comb begin
      prod_d.i = 32'(s1_q) * 32'(rom_cos);
      prod_d.q = 32'(s1_q) * 32'(rom_sin);
   end

   // P2 product register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prod_q <= '0;
      else       prod_q <= prod_d;
   end

   // P3: accumulate; the closing product is folded in and the block mean dumped
   always_comb begin
      sum_i_c     = acc_i_q + ACC_W'(prod_q.i);
      sum_q_c     = acc_q_q + ACC_W'(prod_q.q);
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      i_out_d     = i_out_q;
      q_out_d     = q_out_q;
      out_valid_d = 1'b0;
      if (flush_c) begin
         acc_i_d = '0;
         acc_q_d = '0;
      end else if (v2_q) begin
         if (last2_q) begin
            acc_i_d     = '0;
            acc_q_d     = '0;
            i_out_d     = 32'(sum_i_c >>> LOG2N);
            q_out_d     = 32'(sum_q_c >>> LOG2N);
            out_valid_d = 1'b1;
         end else begin
            acc_i_d = sum_i_c;
            acc_q_d = sum_q_c;
         end
      end
   end

   // P3 accumulator and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         i_out_q     <= i_out_d;
         q_out_q     <= q_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign i_out_o     = i_out_q;
   assign q_out_o     = q_out_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_lockin_demod.sv
// Directed bench for lockin_demod with 16-sample blocks.
module tb_lockin_demod;

   localparam int unsigned LOG2N   = 4;
   localparam int unsigned PHASE_W = 32;
   localparam int unsigned LUT_AW  = 8;

   localparam longint DC_I   = 536854528;   // 16384*32767
   localparam longint QUAD_Q = 268427264;
   localparam longint CLR_IQ = 33553408;    // 16384*32767/16

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [PHASE_W-1:0]  phase_inc;
   logic                phase_clr;
   logic [15:0]         sample;
   logic                sample_valid;
   logic signed [31:0]  i_out;
   logic signed [31:0]  q_out;
   logic                out_valid;
   logic                busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_strobe_cyc = 0;
   int busy_hi_cnt = 0;
   int ov_cyc[$];
   longint ov_i[$];
   longint ov_q[$];

   lockin_demod #(
      .LOG2N   (LOG2N),
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .phase_inc_i    (phase_inc),
      .phase_clr_i    (phase_clr),
      .sample_i       (sample),
      .sample_valid_i (sample_valid),
      .i_out_o        (i_out),
      .q_out_o        (q_out),
      .out_valid_o    (out_valid),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output strobe away from the active edge
   always @(negedge clk) begin
      if (out_valid) begin
         ov_cyc.push_back(cyc);
         ov_i.push_back(longint'(i_out));
         ov_q.push_back(longint'(q_out));
      end
      if (busy) busy_hi_cnt = busy_hi_cnt + 1;
   end

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] v, input logic clr);
      sample          = v;
      sample_valid    = 1'b1;
      phase_clr       = clr;
      last_strobe_cyc = cyc;
      tick();
      sample_valid    = 1'b0;
      phase_clr       = 1'b0;
   endtask

   task automatic clear_mon();
      ov_cyc.delete();
      ov_i.delete();
      ov_q.delete();
      busy_hi_cnt = 0;
   endtask

   // Return to idle, zero the phase, then run with a fresh increment
   task automatic start_run(input logic [PHASE_W-1:0] inc);
      en = 1'b0;
      repeat (2) tick();
      phase_inc = inc;
      phase_clr = 1'b1;
      tick();
      phase_clr = 1'b0;
      en        = 1'b1;
      repeat (2) tick();
   endtask

   logic [15:0] qpat [4];
   logic [15:0] bpat [3];
   longint      bexp [3];

   initial begin
      qpat = '{16'h8000, 16'hC000, 16'h8000, 16'h4000};
      bpat = '{16'hC000, 16'h4000, 16'hA000};
      bexp = '{DC_I, -DC_I, 64'sd268427264};

      rst = 1'b1; en = 1'b0; phase_inc = '0; phase_clr = 1'b0;
      sample = 16'h8000; sample_valid = 1'b0;
      repeat (3) tick();
      check_eq("rst_i_out", i_out, 0);
      check_eq("rst_q_out", q_out, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Idle: strobes ignored
      clear_mon();
      repeat (100) strobe(16'hFFFF, 1'b0);
      repeat (8) tick();
      check_eq("idle_ov_cnt", ov_cyc.size(), 0);
      check_eq("idle_i_out", i_out, 0);
      check_eq("idle_busy_hi", busy_hi_cnt, 0);

      // DC at zero phase
      start_run('0);
      clear_mon();
      strobe(16'hC000, 1'b0);
      check_eq("dc_busy_mid", busy, 1);
      repeat (15) strobe(16'hC000, 1'b0);
      repeat (8) tick();
      check_eq("dc_ov_cnt", ov_cyc.size(), 1);
      check_eq("dc_latency", ov_cyc[0] - last_strobe_cyc, 4);
      check_eq("dc_i_out", ov_i[0], DC_I);
      check_eq("dc_q_out", ov_q[0], 0);
      check_eq("dc_busy_after", busy, 0);

      // Quadrature at a quarter-turn per sample
      start_run(32'h4000_0000);
      clear_mon();
      for (int k = 0; k < 16; k++) strobe(qpat[k % 4], 1'b0);
      repeat (8) tick();
      check_eq("quad_ov_cnt", ov_cyc.size(), 1);
      check_eq("quad_i_out", ov_i[0], 0);
      check_eq("quad_q_out", ov_q[0], QUAD_Q);

      // Back-to-back blocks, one strobe every cycle
      start_run('0);
      clear_mon();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 16; k++) strobe(bpat[b], 1'b0);
      end
      repeat (8) tick();
      check_eq("b2b_ov_cnt", ov_cyc.size(), 3);
      check_eq("b2b_gap0", ov_cyc[1] - ov_cyc[0], 16);
      check_eq("b2b_gap1", ov_cyc[2] - ov_cyc[1], 16);
      for (int b = 0; b < 3; b++) begin
         check_eq($sformatf("b2b_i_out%0d", b), ov_i[b], bexp[b]);
         check_eq($sformatf("b2b_q_out%0d", b), ov_q[b], 0);
      end

      // Abort mid-block, then a clean block
      start_run('0);
      clear_mon();
      repeat (7) strobe(16'h4000, 1'b0);
      en = 1'b0;
      repeat (3) tick();
      check_eq("abort_busy_idle", busy, 0);
      en = 1'b1;
      repeat (2) tick();
      repeat (16) strobe(16'hC000, 1'b0);
      repeat (8) tick();
      check_eq("abort_ov_cnt", ov_cyc.size(), 1);
      check_eq("abort_i_out", ov_i[0], DC_I);

      // phase_clr coincident with the third strobe
      start_run(32'h4000_0000);
      clear_mon();
      for (int k = 0; k < 16; k++) strobe(16'hC000, k == 2);
      repeat (8) tick();
      check_eq("clr_ov_cnt", ov_cyc.size(), 1);
      check_eq("clr_i_out", ov_i[0], CLR_IQ);
      check_eq("clr_q_out", ov_q[0], CLR_IQ);

      // Outputs hold between strobes
      repeat (20) tick();
      check_eq("hold_i_out", i_out, CLR_IQ);
      check_eq("hold_q_out", q_out, CLR_IQ);

      // Reset in the middle of a block
      start_run('0);
      clear_mon();
      repeat (5) strobe(16'hC000, 1'b0);
      rst = 1'b1;
      tick();
      check_eq("mrst_i_out", i_out, 0);
      check_eq("mrst_q_out", q_out, 0);
      check_eq("mrst_busy", busy, 0);
      en  = 1'b0;
      rst = 1'b0;
      repeat (10) tick();
      check_eq("mrst_ov_cnt", ov_cyc.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
